// File: rtl/fetch_redirect_ctrl_if.sv
// Fetch redirect bus: WB flush, ID branch and IF request signals
// grouped between the redirect controller and its surroundings.
interface fetch_redirect_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             fs_allowin;
    logic             excp_flush;
    logic             eret_flush;
    logic [31:0]      cp0_epc;
    logic             br_valid;
    logic             br_resolved;
    logic             br_taken;
    logic [31:0]      br_target;
    logic             pc_req_valid;
    logic [31:0]      pc_req_addr;
    logic             fs_flush;
    logic [31:0]      fs_pc;
    logic [CNT_W-1:0] br_stall_cnt;

    modport master (
        input  fs_allowin, excp_flush, eret_flush, cp0_epc,
        input  br_valid, br_resolved, br_taken, br_target,
        output pc_req_valid, pc_req_addr, fs_flush, fs_pc,
        output br_stall_cnt
    );

    modport slave (
        output fs_allowin, excp_flush, eret_flush, cp0_epc,
        output br_valid, br_resolved, br_taken, br_target,
        input  pc_req_valid, pc_req_addr, fs_flush, fs_pc,
        input  br_stall_cnt
    );
endinterface

// File: rtl/fetch_redirect_ctrl.sv
// Next-PC sequencer for IF: owns the fetch PC, arbitrates flushes
// and branches, and parks redirects that cannot issue immediately.
module fetch_redirect_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hbfc00000,
    parameter logic [31:0] EXCP_PC  = 32'hbfc00380,
    parameter int          CNT_W    = 16
) (
    input logic                 clk,
    input logic                 resetn,
    fetch_redirect_ctrl_if.master bus
);
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        REDIR = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      fs_pc_q, fs_pc_d;
    logic [31:0]      pend_pc_q, pend_pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        flush, br_wait, br_tk, issue;
    logic        req_valid;
    logic [31:0] req_addr;

    assign flush   = bus.excp_flush | bus.eret_flush;
    assign br_wait = bus.br_valid & ~bus.br_resolved;
    assign br_tk   = bus.br_valid & bus.br_resolved & bus.br_taken;

    // Request is a function of state and flush/branch only, never fs_allowin
    always_comb begin
        req_valid = 1'b0;
        req_addr  = fs_pc_q + 32'd4;
        unique case (state_q)
            BOOT: ;
            RUN: begin
                req_valid = ~br_wait & ~flush;
                if (br_tk) req_addr = bus.br_target;
            end
            REDIR: begin
                req_valid = ~flush;
                req_addr  = pend_pc_q;
            end
            default: ;
        endcase
    end

    assign issue = req_valid & bus.fs_allowin;

    always_comb begin
        state_d   = state_q;
        fs_pc_d   = fs_pc_q;
        pend_pc_d = pend_pc_q;
        cnt_d     = cnt_q;
        if (issue) fs_pc_d = req_addr;
        if (bus.excp_flush) begin
            pend_pc_d = EXCP_PC;
            state_d   = REDIR;
        end else if (bus.eret_flush) begin
            pend_pc_d = bus.cp0_epc;
            state_d   = REDIR;
        end else begin
            unique case (state_q)
                BOOT: state_d = RUN;
                RUN: begin
                    // Park a taken target so a later ID change cannot lose it
                    if (br_tk && !bus.fs_allowin) begin
                        pend_pc_d = bus.br_target;
                        state_d   = REDIR;
                    end
                    if (br_wait && !(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
                end
                REDIR: if (bus.fs_allowin) state_d = RUN;
                default: state_d = BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= BOOT;
            fs_pc_q   <= RESET_PC - 32'd4;
            pend_pc_q <= 32'd0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            fs_pc_q   <= fs_pc_d;
            pend_pc_q <= pend_pc_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.pc_req_valid = req_valid & resetn;
    assign bus.pc_req_addr  = req_addr;
    assign bus.fs_flush     = flush & resetn;
    assign bus.fs_pc        = fs_pc_q;
    assign bus.br_stall_cnt = cnt_q;
endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl: vector table plus
// hand sequences for async reset and counter saturation.
module tb_fetch_redirect_ctrl;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    fetch_redirect_ctrl_if #(.CNT_W(16)) bus ();
    fetch_redirect_ctrl_if #(.CNT_W(3))  bus_s ();

    fetch_redirect_ctrl #(.CNT_W(16)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    fetch_redirect_ctrl #(.CNT_W(3)) u_sat (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_s)
    );

    typedef struct {
        logic        ain, ex, er;
        logic [31:0] epc;
        logic        bv, br, bt;
        logic [31:0] tgt;
        logic        v;
        logic [31:0] a;
        logic        fl;
        logic [31:0] pc;
        logic [15:0] cnt;
    } vec_t;

    localparam int NV = 25;
    vec_t tbl [NV];
    int total = 0;
    int passed = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %08h want %08h", nm, act, exp);
    endtask

    task automatic drive(input vec_t t);
        bus.fs_allowin  = t.ain;
        bus.excp_flush  = t.ex;
        bus.eret_flush  = t.er;
        bus.cp0_epc     = t.epc;
        bus.br_valid    = t.bv;
        bus.br_resolved = t.br;
        bus.br_taken    = t.bt;
        bus.br_target   = t.tgt;
    endtask

    initial begin
        //        ain ex er epc          bv br bt tgt           v  addr          fl pc            cnt
        tbl[0]  = '{1,0,0,32'h0,        0,0,0,32'h0,        0,32'h0,        0,32'hbfbffffc,16'd0};
        tbl[1]  = '{1,0,0,32'h0,        0,0,0,32'h0,        1,32'hbfc00000,0,32'hbfbffffc,16'd0};
        tbl[2]  = '{1,0,0,32'h0,        0,0,0,32'h0,        1,32'hbfc00004,0,32'hbfc00000,16'd0};
        tbl[3]  = '{1,0,0,32'h0,        0,0,0,32'h0,        1,32'hbfc00008,0,32'hbfc00004,16'd0};
        tbl[4]  = '{1,0,0,32'h0,        0,0,0,32'h0,        1,32'hbfc0000c,0,32'hbfc00008,16'd0};
        tbl[5]  = '{1,0,0,32'h0,        0,0,0,32'h0,        1,32'hbfc00010,0,32'hbfc0000c,16'd0};
        tbl[6]  = '{1,0,0,32'h0,        1,0,0,32'h0,        0,32'h0,        0,32'hbfc00010,16'd0};
        tbl[7]  = '{1,0,0,32'h0,        1,0,0,32'h0,        0,32'h0,        0,32'hbfc00010,16'd1};
        tbl[8]  = '{1,0,0,32'h0,        1,0,0,32'h0,        0,32'h0,        0,32'hbfc00010,16'd2};
        tbl[9]  = '{1,0,0,32'h0,        1,1,1,32'hbfc00100,1,32'hbfc00100,0,32'hbfc00010,16'd3};
        tbl[10] = '{1,0,0,32'h0,        0,0,0,32'h0,        1,32'hbfc00104,0,32'hbfc00100,16'd3};
        tbl[11] = '{0,0,0,32'h0,        1,1,1,32'hbfc00200,1,32'hbfc00200,0,32'hbfc00104,16'd3};
        tbl[12] = '{0,0,0,32'h0,        1,0,0,32'hbfc00999,1,32'hbfc00200,0,32'hbfc00104,16'd3};
        tbl[13] = '{1,0,0,32'h0,        0,0,0,32'h0,        1,32'hbfc00200,0,32'hbfc00104,16'd3};
        tbl[14] = '{1,0,0,32'h0,        0,0,0,32'h0,        1,32'hbfc00204,0,32'hbfc00200,16'd3};
        tbl[15] = '{1,1,1,32'hbfc00040,1,1,1,32'hbfc00300,0,32'h0,        1,32'hbfc00204,16'd3};
        tbl[16] = '{1,0,0,32'h0,        0,0,0,32'h0,        1,32'hbfc00380,0,32'hbfc00204,16'd3};
        tbl[17] = '{1,0,0,32'h0,        0,0,0,32'h0,        1,32'hbfc00384,0,32'hbfc00380,16'd3};
        tbl[18] = '{0,0,1,32'hbfc00040,0,0,0,32'h0,        0,32'h0,        1,32'hbfc00384,16'd3};
        tbl[19] = '{0,0,0,32'h0,        0,0,0,32'h0,        1,32'hbfc00040,0,32'hbfc00384,16'd3};
        tbl[20] = '{0,1,0,32'h0,        0,0,0,32'h0,        0,32'h0,        1,32'hbfc00384,16'd3};
        tbl[21] = '{0,0,0,32'h0,        0,0,0,32'h0,        1,32'hbfc00380,0,32'hbfc00384,16'd3};
        tbl[22] = '{1,0,0,32'h0,        0,0,0,32'h0,        1,32'hbfc00380,0,32'hbfc00384,16'd3};
        tbl[23] = '{1,0,0,32'h0,        0,0,0,32'h0,        1,32'hbfc00384,0,32'hbfc00380,16'd3};
        tbl[24] = '{1,0,0,32'h0,        1,1,0,32'hbfc00500,1,32'hbfc00388,0,32'hbfc00384,16'd3};

        drive('{0,0,0,32'h0,0,0,0,32'h0,0,32'h0,0,32'h0,16'd0});
        bus_s.fs_allowin  = 1'b1;
        bus_s.excp_flush  = 1'b0;
        bus_s.eret_flush  = 1'b0;
        bus_s.cp0_epc     = 32'h0;
        bus_s.br_valid    = 1'b0;
        bus_s.br_resolved = 1'b0;
        bus_s.br_taken    = 1'b0;
        bus_s.br_target   = 32'h0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst valid", 32'(bus.pc_req_valid), 32'd0);
        chk("rst flush", 32'(bus.fs_flush), 32'd0);
        chk("rst fs_pc", bus.fs_pc, 32'hbfbffffc);
        chk("rst cnt", 32'(bus.br_stall_cnt), 32'd0);

        @(posedge clk);
        #2 resetn = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            chk($sformatf("r%0d valid", i), 32'(bus.pc_req_valid), 32'(tbl[i].v));
            chk($sformatf("r%0d flush", i), 32'(bus.fs_flush), 32'(tbl[i].fl));
            chk($sformatf("r%0d fs_pc", i), bus.fs_pc, tbl[i].pc);
            chk($sformatf("r%0d cnt", i), 32'(bus.br_stall_cnt), 32'(tbl[i].cnt));
            if (tbl[i].v)
                chk($sformatf("r%0d addr", i), bus.pc_req_addr, tbl[i].a);
        end

        // Async reset while parked in REDIR
        @(negedge clk);
        drive('{0,0,1,32'h00001234,0,0,0,32'h0,0,32'h0,0,32'h0,16'd0});
        @(negedge clk);
        bus.eret_flush = 1'b0;
        #1;
        chk("redir valid", 32'(bus.pc_req_valid), 32'd1);
        chk("redir addr", bus.pc_req_addr, 32'h00001234);
        #2;
        resetn = 1'b0;
        bus.eret_flush = 1'b1;
        #1;
        chk("async valid", 32'(bus.pc_req_valid), 32'd0);
        chk("async flush", 32'(bus.fs_flush), 32'd0);
        chk("async fs_pc", bus.fs_pc, 32'hbfbffffc);
        chk("async cnt", 32'(bus.br_stall_cnt), 32'd0);
        @(negedge clk);
        bus.eret_flush = 1'b0;
        bus.fs_allowin = 1'b1;
        @(posedge clk);
        #2 resetn = 1'b1;
        @(negedge clk);
        #1;
        chk("boot2 valid", 32'(bus.pc_req_valid), 32'd0);
        @(negedge clk);
        #1;
        chk("boot2 valid1", 32'(bus.pc_req_valid), 32'd1);
        chk("boot2 addr", bus.pc_req_addr, 32'hbfc00000);

        // Saturation on the narrow-counter instance, now in RUN
        bus_s.br_valid = 1'b1;
        for (int k = 0; k < 12; k++) begin
            #1;
            chk($sformatf("sat k%0d", k), 32'(bus_s.br_stall_cnt),
                32'((k < 7) ? k : 7));
            @(negedge clk);
        end
        bus_s.br_valid = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
